// File: rtl/game_pkg.sv
// game_pkg
// Shared definitions for the sliding-tile puzzle: the game_status codes
// exchanged with the game-status FSM, the board controller state encoding,
// the direction codes, the preset scrambles and the solved board.
//
// Boards are stored here in a fixed 4-bit-per-tile packed form. Position p
// (p = row*3 + col) lives at bits [p*4 +: 4]. The controller widens them to
// its own tile width.
package game_pkg;

  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAMING       = 2'b01,
    GAME_INITIAL = 2'b10,
    WINNED       = 2'b11
  } game_status_t;

  typedef enum logic [1:0] {
    S_LOAD,
    S_WAIT,
    S_SWAP,
    S_CHECK
  } ctrl_state_t;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  localparam int TILE_CODE_W  = 4;
  localparam int BOARD_CODE_W = 9 * TILE_CODE_W;

  // Hex digits read from position 8 (left) down to position 0 (right).
  localparam logic [BOARD_CODE_W-1:0] PRESET0 = 36'h807654321;
  localparam logic [BOARD_CODE_W-1:0] PRESET1 = 36'h857604321;
  localparam logic [BOARD_CODE_W-1:0] PRESET2 = 36'h850627314;
  localparam logic [BOARD_CODE_W-1:0] PRESET3 = 36'h687354210;
  localparam logic [BOARD_CODE_W-1:0] SOLVED  = 36'h087654321;

  localparam logic [3:0] PRESET0_BLANK = 4'd7;
  localparam logic [3:0] PRESET1_BLANK = 4'd4;
  localparam logic [3:0] PRESET2_BLANK = 4'd6;
  localparam logic [3:0] PRESET3_BLANK = 4'd0;

  function automatic logic [BOARD_CODE_W-1:0] presetBoard(input logic [1:0] sel);
    case (sel)
      2'd0:    return PRESET0;
      2'd1:    return PRESET1;
      2'd2:    return PRESET2;
      default: return PRESET3;
    endcase
  endfunction

  function automatic logic [3:0] presetBlank(input logic [1:0] sel);
    case (sel)
      2'd0:    return PRESET0_BLANK;
      2'd1:    return PRESET1_BLANK;
      2'd2:    return PRESET2_BLANK;
      default: return PRESET3_BLANK;
    endcase
  endfunction

  function automatic logic [1:0] posRow(input logic [3:0] p);
    if (p >= 4'd6)      return 2'd2;
    else if (p >= 4'd3) return 2'd1;
    else                return 2'd0;
  endfunction

  function automatic logic [1:0] posCol(input logic [3:0] p);
    case (p)
      4'd0, 4'd3, 4'd6: return 2'd0;
      4'd1, 4'd4, 4'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  // A move is legal only if the neighbour in that direction is on the board.
  function automatic logic moveLegal(input dir_t dir, input logic [3:0] p);
    case (dir)
      DIR_UP:    return posRow(p) != 2'd0;
      DIR_DOWN:  return posRow(p) != 2'd2;
      DIR_LEFT:  return posCol(p) != 2'd0;
      default:   return posCol(p) != 2'd2;
    endcase
  endfunction

  // Neighbour position; only meaningful when moveLegal holds.
  function automatic logic [3:0] moveTarget(input dir_t dir, input logic [3:0] p);
    case (dir)
      DIR_UP:    return p - 4'd3;
      DIR_DOWN:  return p + 4'd3;
      DIR_LEFT:  return p - 4'd1;
      default:   return p + 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/board_ctrl_btn_edge.sv
// btn_edge
// Press detector for one debounced button. A press is the button at its
// active level this cycle while it was not at that level the cycle before.
// The history register resets to "pressed" so a button held through reset
// does not produce a press when reset is released.
//
// Ports:
//   clk_d    system clock
//   rst      synchronous active-high reset
//   i_btn    debounced button level
//   o_press  single-cycle press indication (combinational on i_btn)
module btn_edge #(
  parameter bit POL = 1'b1
) (
  input  logic clk_d,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  logic w_level;
  logic r_prevLevel;

  assign w_level = (i_btn == POL);

  // History tracks the button every cycle, whatever the controller is doing.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      r_prevLevel <= 1'b1;
    end else begin
      r_prevLevel <= w_level;
    end
  end

  assign o_press = w_level & ~r_prevLevel;

endmodule

// File: rtl/board_ctrl.sv
// board_ctrl
// Board datapath and move controller for the 3x3 sliding-tile game. Holds
// the board, loads the preset chosen by board_sel, turns direction presses
// into blank-tile moves and reports moves, restarts and the win condition
// to the game-status FSM.
//
// Ports:
//   clk_d        system clock
//   rst          synchronous active-high reset
//   game_status  state of the game-status FSM
//   board_sel    preset board index 0..3
//   btn_up/down/left/right  debounced direction buttons
//   btn_reset    debounced restart-this-board button
//   active       one-cycle pulse per legal move
//   reset_flag   one-cycle pulse on restart
//   win_flag     high while the board is solved (updated after each move)
//   board        tile at position p is board[p*TILE_W +: TILE_W]
//   blank_pos    position of the blank tile, 0..8
module board_ctrl
  import game_pkg::*;
#(
  parameter int TILE_W  = 4,
  parameter bit BTN_POL = 1'b1
) (
  input  logic                clk_d,
  input  logic                rst,
  input  logic [1:0]          game_status,
  input  logic [1:0]          board_sel,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_reset,
  output logic                active,
  output logic                reset_flag,
  output logic                win_flag,
  output logic [9*TILE_W-1:0] board,
  output logic [3:0]          blank_pos
);

  function automatic logic [9*TILE_W-1:0] expandBoard(input logic [BOARD_CODE_W-1:0] src);
    logic [9*TILE_W-1:0] dst;
    dst = '0;
    for (int p = 0; p < 9; p++) begin
      dst[p*TILE_W +: TILE_W] = TILE_W'(src[p*TILE_CODE_W +: TILE_CODE_W]);
    end
    return dst;
  endfunction

  game_status_t        w_status;
  logic                w_pressUp;
  logic                w_pressDown;
  logic                w_pressLeft;
  logic                w_pressRight;
  logic                w_pressReset;
  logic                w_moveValid;
  dir_t                w_moveDir;
  logic                w_moveLegal;
  logic [3:0]          w_target;
  logic [TILE_W-1:0]   w_neighbourTile;
  logic [9*TILE_W-1:0] w_swapped;
  logic [9*TILE_W-1:0] w_presetBoard;
  logic [3:0]          w_presetBlank;
  logic [9*TILE_W-1:0] w_solvedBoard;

  ctrl_state_t         r_state;
  dir_t                r_dir;
  logic [9*TILE_W-1:0] r_board;
  logic [3:0]          r_blank;
  logic                r_active;
  logic                r_resetFlag;
  logic                r_win;

  assign w_status      = game_status_t'(game_status);
  assign w_presetBoard = expandBoard(presetBoard(board_sel));
  assign w_presetBlank = presetBlank(board_sel);
  assign w_solvedBoard = expandBoard(SOLVED);

  btn_edge #(.POL(BTN_POL)) u_edgeUp    (.clk_d(clk_d), .rst(rst), .i_btn(btn_up),    .o_press(w_pressUp));
  btn_edge #(.POL(BTN_POL)) u_edgeDown  (.clk_d(clk_d), .rst(rst), .i_btn(btn_down),  .o_press(w_pressDown));
  btn_edge #(.POL(BTN_POL)) u_edgeLeft  (.clk_d(clk_d), .rst(rst), .i_btn(btn_left),  .o_press(w_pressLeft));
  btn_edge #(.POL(BTN_POL)) u_edgeRight (.clk_d(clk_d), .rst(rst), .i_btn(btn_right), .o_press(w_pressRight));
  btn_edge #(.POL(BTN_POL)) u_edgeReset (.clk_d(clk_d), .rst(rst), .i_btn(btn_reset), .o_press(w_pressReset));

  // Simultaneous direction presses resolve as up > down > left > right.
  always_comb begin
    w_moveValid = 1'b1;
    w_moveDir   = DIR_UP;
    if (w_pressUp) begin
      w_moveDir = DIR_UP;
    end else if (w_pressDown) begin
      w_moveDir = DIR_DOWN;
    end else if (w_pressLeft) begin
      w_moveDir = DIR_LEFT;
    end else if (w_pressRight) begin
      w_moveDir = DIR_RIGHT;
    end else begin
      w_moveValid = 1'b0;
    end
  end

  assign w_moveLegal = moveLegal(w_moveDir, r_blank);

  // The swap uses the direction latched when the press was accepted, so
  // the neighbour is derived from r_dir rather than the live buttons.
  assign w_target = moveTarget(r_dir, r_blank);

  always_comb begin
    w_neighbourTile = '0;
    w_swapped       = r_board;
    for (int p = 0; p < 9; p++) begin
      if (4'(p) == w_target) begin
        w_neighbourTile = r_board[p*TILE_W +: TILE_W];
      end
    end
    for (int p = 0; p < 9; p++) begin
      if (4'(p) == r_blank) begin
        w_swapped[p*TILE_W +: TILE_W] = w_neighbourTile;
      end else if (4'(p) == w_target) begin
        w_swapped[p*TILE_W +: TILE_W] = '0;
      end
    end
  end

  // Controller FSM with registered outputs. CHOSE_BOARD from the game FSM
  // overrides every state: any swap in flight is dropped and the selected
  // preset is loaded straight away, as S_LOAD would do.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_dir       <= DIR_UP;
      r_board     <= expandBoard(PRESET0);
      r_blank     <= PRESET0_BLANK;
      r_active    <= 1'b0;
      r_resetFlag <= 1'b0;
      r_win       <= 1'b0;
    end else begin
      r_active    <= 1'b0;
      r_resetFlag <= 1'b0;
      if (w_status == CHOSE_BOARD) begin
        r_state <= S_LOAD;
        r_board <= w_presetBoard;
        r_blank <= w_presetBlank;
        r_win   <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            r_board <= w_presetBoard;
            r_blank <= w_presetBlank;
            r_win   <= 1'b0;
            if (w_status == GAMING || w_status == GAME_INITIAL) begin
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (w_status != WINNED) begin
              if (w_pressReset) begin
                r_board     <= w_presetBoard;
                r_blank     <= w_presetBlank;
                r_resetFlag <= 1'b1;
                r_win       <= 1'b0;
              end else if (w_moveValid) begin
                r_dir <= w_moveDir;
                if (w_moveLegal) begin
                  r_state <= S_SWAP;
                end
              end
            end
          end
          S_SWAP: begin
            r_board  <= w_swapped;
            r_blank  <= w_target;
            r_active <= 1'b1;
            r_state  <= S_CHECK;
          end
          S_CHECK: begin
            r_win   <= (r_board == w_solvedBoard);
            r_state <= S_WAIT;
          end
          default: begin
            r_state <= S_LOAD;
          end
        endcase
      end
    end
  end

  assign board      = r_board;
  assign blank_pos  = r_blank;
  assign active     = r_active;
  assign reset_flag = r_resetFlag;
  assign win_flag   = r_win;

endmodule

// File: doc/board_ctrl.md
Name: board_ctrl

Overview:
Puzzle-board datapath/controller for the 3x3 sliding-tile game, directly upstream of the game-status FSM.
- Holds the board and loads a preset scramble selected by board_sel.
- Turns direction-button presses into blank-tile moves.
- Produces the one-cycle active pulse per legal move, the reset_flag pulse, and the win_flag level.
- Consumes game_status from the FSM to know when moves are allowed.

Parameters:
- TILE_W, 4, bits per tile code; tile 0 is the blank, tiles 1..8 are numbered.
- BTN_POL, 1, button active level; 1 means pressed = high, 0 means pressed = low.

Ports:
- clk_d  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- game_status  in  2  from FSM: 00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED.
- board_sel  in  2  preset board index 0..3.
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced direction buttons.
- btn_reset  in  1  debounced "restart this board" button.
- active  out  1  one-cycle pulse per legal move.
- reset_flag  out  1  one-cycle pulse on restart.
- win_flag  out  1  level, high while the board equals SOLVED.
- board  out  9*TILE_W  tile at position p (p = row*3 + col) is board[p*TILE_W +: TILE_W].
- blank_pos  out  4  position of tile 0, range 0..8.

Behaviour:
Reset (synchronous, rst = 1):
- board = PRESET0, blank_pos = 7.
- active, reset_flag, win_flag = 0.
- state = S_LOAD.
- All button history registers set to "pressed", so a button held through reset does not fire.

Edge detection:
- press = button at its active level this cycle AND not at that level in the previous cycle.
- History registers update every cycle, in every state.

State machine (S_LOAD, S_WAIT, S_SWAP, S_CHECK):
- S_LOAD:
  - Every cycle: board = PRESET[board_sel], blank_pos = its blank position, win_flag = 0.
  - Exit to S_WAIT when game_status is 01 or 10.
- S_WAIT:
  - btn_reset press: reload PRESET[board_sel]; reset_flag = 1 for one cycle; win_flag = 0; stay in S_WAIT.
  - Reset has priority over any direction press in the same cycle.
  - Otherwise, the highest-priority direction press (up > down > left > right) is latched.
  - If that move is legal, go to S_SWAP.
  - An illegal press (blank on that edge) is dropped: no pulse, no board change.
- S_SWAP (one cycle):
  - Swap the blank with its neighbour: up = p-3, down = p+3, left = p-1, right = p+1.
  - Legal only if: up needs row > 0; down needs row < 2; left needs col > 0; right needs col < 2.
  - The board update, the blank_pos update, and active = 1 all become visible on the same clock edge.
  - Next state is S_CHECK.
- S_CHECK (one cycle):
  - win_flag = (board == SOLVED), visible one cycle after the active pulse.
  - Next state is S_WAIT.

Cross-state rules:
- Presses arriving during S_SWAP or S_CHECK are ignored, not queued.
- game_status = 11 (WINNED) in S_WAIT: every press is ignored and the board is frozen.
- game_status = 00 in any state: next state is S_LOAD. A swap in progress is abandoned and no active pulse is issued.
- Exactly one of active and reset_flag is high in any cycle, or neither.

Presets (rows listed top to bottom):
- PRESET0: 1 2 3 / 4 5 6 / 7 0 8, blank at 7.
- PRESET1: 1 2 3 / 4 0 6 / 7 5 8, blank at 4.
- PRESET2: 4 1 3 / 7 2 6 / 0 5 8, blank at 6.
- PRESET3: 0 1 2 / 4 5 3 / 7 8 6, blank at 0.
- SOLVED: 1 2 3 / 4 5 6 / 7 8 0.
- All presets are reachable from SOLVED. None equals SOLVED.

Decomposition:
- Shared package game_pkg holds:
  - the game_status codes (CHOSE_BOARD, GAMING, GAME_INITIAL, WINNED), shared with the FSM;
  - the board_ctrl state encodings;
  - the direction codes;
  - PRESET0..3, their blank positions, and SOLVED.
- One sub-module, btn_edge: a parameterised-polarity press detector, instantiated five times.
- Neighbour/legality logic and the swap stay inline.

Test Plan:
1. Reset with btn_right held, then game_status = 10, board_sel = 0 -> no move while held. Release, then press right -> board = SOLVED and blank_pos = 8 in the same cycle as the one-cycle active pulse; win_flag = 1 on the next cycle.
2. board_sel = 0 and game_status = 01, press down (blank at 7, row 2) -> illegal: no active pulse, board unchanged, win_flag = 0.
3. board_sel = 3, presses right, right, down, down -> exactly 4 active pulses; blank_pos sequence 1, 2, 5, 8; win_flag = 1 after the last one. Then game_status = 11 and press left -> no pulse, board unchanged.
4. board_sel = 1, press down and then btn_reset -> reset_flag pulses once, board = PRESET1, blank_pos = 4. Pressing btn_reset and btn_up in the same cycle -> only reset_flag, no active pulse.
5. Press up and left in the same cycle with blank at 4 -> only the up move is executed (blank_pos = 1), with a single active pulse.
6. Drive game_status = 00 in the cycle the FSM enters S_SWAP -> no active pulse; board = PRESET[board_sel] on the next cycle; win_flag = 0.
